// File: rtl/sccb_target.sv
// SCCB (I2C-compatible subset) target: acknowledges DEVICE_ID, turns 3-phase writes into
// register-write strobes and serves 2-phase reads from an external register bank.
`timescale 1ns/1ps
module sccb_target #(
    parameter logic [7:0] DEVICE_ID = 8'h42
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sioc_in,
    input  logic       siod_in,
    output logic       siod_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ID,
        S_ID_ACK,
        S_SUB,
        S_SUB_ACK,
        S_DATA,
        S_DATA_ACK,
        S_RD_LOAD,
        S_RD_DATA,
        S_WAIT_STOP
    } state_t;

    state_t state, state_nxt;

    logic [1:0] sioc_sync, siod_sync;
    logic       sioc_hist, siod_hist;
    logic       sioc_s, siod_s;
    logic       rise, fall, start_det, stop_det;

    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       byte_full;
    logic       rd_wait;
    logic       shifting;
    logic       last_bit_rise;
    logic       id_match;

    logic       oe_nxt, we_nxt, re_nxt;

    // Synchronizers idle high so that leaving reset never fakes an edge on an idle bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sioc_sync <= 2'b11;
            siod_sync <= 2'b11;
            sioc_hist <= 1'b1;
            siod_hist <= 1'b1;
        end else begin
            sioc_sync <= {sioc_sync[0], sioc_in};
            siod_sync <= {siod_sync[0], siod_in};
            sioc_hist <= sioc_sync[1];
            siod_hist <= siod_sync[1];
        end
    end

    assign sioc_s    = sioc_sync[1];
    assign siod_s    = siod_sync[1];
    assign rise      = sioc_s & ~sioc_hist;
    assign fall      = ~sioc_s & sioc_hist;
    assign start_det = sioc_s & sioc_hist & siod_hist & ~siod_s;
    assign stop_det  = sioc_s & sioc_hist & ~siod_hist & siod_s;

    assign shifting      = (state == S_ID) || (state == S_SUB) || (state == S_DATA);
    assign last_bit_rise = rise && !byte_full && (bit_cnt == 3'd7);
    assign id_match      = (shreg[7:1] == DEVICE_ID[7:1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (stop_det) begin
            state_nxt = S_IDLE;
        end else if (start_det) begin
            state_nxt = S_ID;
        end else begin
            case (state)
                S_IDLE:      state_nxt = S_IDLE;
                S_ID:        if (fall && byte_full) state_nxt = id_match ? S_ID_ACK : S_WAIT_STOP;
                S_ID_ACK:    if (fall) state_nxt = shreg[0] ? S_RD_LOAD : S_SUB;
                S_SUB:       if (fall && byte_full) state_nxt = S_SUB_ACK;
                S_SUB_ACK:   if (fall) state_nxt = S_DATA;
                S_DATA:      if (fall && byte_full) state_nxt = S_DATA_ACK;
                S_DATA_ACK:  if (fall) state_nxt = S_WAIT_STOP;
                S_RD_LOAD:   if (rd_wait) state_nxt = S_RD_DATA;
                S_RD_DATA:   if (fall && bit_cnt == 3'd7) state_nxt = S_WAIT_STOP;
                S_WAIT_STOP: state_nxt = S_WAIT_STOP;
                default:     state_nxt = S_IDLE;
            endcase
        end
    end

    // SIOD only moves on a detected SIOC fall, apart from bus conditions and the read preload.
    always_comb begin
        oe_nxt = siod_oe;
        we_nxt = 1'b0;
        re_nxt = 1'b0;
        busy   = (state != S_IDLE);
        if (stop_det || start_det) begin
            oe_nxt = 1'b0;
        end else begin
            case (state)
                S_ID:       if (fall && byte_full) oe_nxt = id_match;
                S_ID_ACK: begin
                    if (fall) begin
                        oe_nxt = 1'b0;
                        re_nxt = shreg[0];
                    end
                end
                S_SUB:      if (fall && byte_full) oe_nxt = 1'b1;
                S_DATA: begin
                    if (fall && byte_full) oe_nxt = 1'b1;
                    we_nxt = (state == S_DATA) && last_bit_rise;
                end
                S_SUB_ACK,
                S_DATA_ACK: if (fall) oe_nxt = 1'b0;
                S_RD_LOAD:  if (rd_wait) oe_nxt = ~reg_rdata[7];
                S_RD_DATA:  if (fall) oe_nxt = (bit_cnt == 3'd7) ? 1'b0 : ~shreg[6];
                default:    oe_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            siod_oe   <= 1'b0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            shreg     <= 8'h00;
            bit_cnt   <= 3'd0;
            byte_full <= 1'b0;
            rd_wait   <= 1'b0;
        end else begin
            siod_oe <= oe_nxt;
            reg_we  <= we_nxt;
            reg_re  <= re_nxt;

            if (start_det || stop_det || (state_nxt != state)) begin
                bit_cnt   <= 3'd0;
                byte_full <= 1'b0;
                rd_wait   <= 1'b0;
            end else if (rise && shifting && !byte_full) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) byte_full <= 1'b1;
            end else if (fall && state == S_RD_DATA) begin
                bit_cnt <= bit_cnt + 3'd1;
            end else if (state == S_RD_LOAD) begin
                rd_wait <= 1'b1;
            end

            if (state == S_RD_LOAD && rd_wait) begin
                shreg <= reg_rdata;
            end else if (state == S_RD_DATA && fall) begin
                shreg <= {shreg[6:0], 1'b0};
            end else if (rise && shifting && !byte_full) begin
                shreg <= {shreg[6:0], siod_s};
            end

            if (state == S_SUB && last_bit_rise) reg_addr <= {shreg[6:0], siod_s};
            if (state == S_DATA && last_bit_rise) reg_wdata <= {shreg[6:0], siod_s};
        end
    end

endmodule
